// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       branch;
    logic [3:0] alu_op;
    logic       is_lw;
    logic       is_sw;
    logic       legal;
  } ctrl_t;

  localparam int    CTRL_W    = $bits(ctrl_t);
  localparam ctrl_t CTRL_NONE = '0;

  // R-type funct to {legal, ALU code}; unknown functs come back not legal.
  function automatic logic [4:0] rtype_alu(input logic [5:0] funct);
    logic [4:0] r;
    r = 5'b0;
    case (funct)
      FN_ADD:  r = {1'b1, ALU_ADD};
      FN_SUB:  r = {1'b1, ALU_SUB};
      FN_AND:  r = {1'b1, ALU_AND};
      FN_OR:   r = {1'b1, ALU_OR};
      FN_SLT:  r = {1'b1, ALU_SLT};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational instruction decode: opcode/funct to the datapath control bundle.
// Latency: 0 cycles (pure combinational; the caller registers the result).
// Backpressure: none.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]        op_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t ctrl;
  logic [4:0] rt_alu;

  assign rt_alu = rtype_alu(funct_i);
  assign ctrl_o = ctrl;

  // Anything not explicitly listed decodes to all-zero with legal=0.
  always_comb begin
    ctrl = CTRL_NONE;
    case (op_i)
      OP_RTYPE: begin
        ctrl.alu_op = rt_alu[3:0];
        ctrl.legal  = rt_alu[4];
      end
      OP_ADDI: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.legal   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.is_lw      = 1'b1;
        ctrl.legal      = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.is_sw   = 1'b1;
        ctrl.legal   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        ctrl.legal  = 1'b1;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: owns PC/IR, fetches over req/ack, steps FETCH..WB.
// Latency: N+3 (R-type/addi/sw), N+4 (lw), N+2 (beq) cycles, N = FETCH cycles until ack.
// Backpressure: imem_req/imem_addr held in FETCH until imem_ack; run low parks in IDLE between instructions.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ins,
  input  logic            zero,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            Branch,
  output logic            ALUSrc,
  output logic            RegDst,
  output logic            RegWrite,
  output logic [3:0]      ALUOp,
  output logic            halted,
  output logic            illegal
);

  state_t          state_q, state_d, next_fetch;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  ctrl_t           ctrl_q, ctrl_d, dec_ctrl;
  logic            illegal_q, illegal_d;
  logic [PC_W-1:0] br_off;

  control_decode u_decode (
    .op_i    (ir_q[31:26]),
    .funct_i (ir_q[5:0]),
    .ctrl_o  (dec_ctrl)
  );

  // Branch offset: sign-extended imm16 in words, wrapped to the PC width.
  assign br_off = PC_W'({{PC_W{ir_q[15]}}, ir_q[15:0], 2'b00});

  // Next-state, PC, IR and control-bundle updates; run is only looked at when heading back to FETCH.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ctrl_d     = ctrl_q;
    illegal_d  = illegal_q;
    next_fetch = run ? S_FETCH : S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ctrl.legal) begin
          ctrl_d  = dec_ctrl;
          state_d = S_EXEC;
        end else begin
          ctrl_d    = CTRL_NONE;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        if (ctrl_q.branch) begin
          if (zero) pc_d = pc_q + br_off;
          state_d = next_fetch;
        end else if (ctrl_q.is_lw || ctrl_q.is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM:   state_d = ctrl_q.is_lw ? S_WB : next_fetch;
      S_WB:    state_d = next_fetch;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC, IR and registered controls; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ctrl_q    <= CTRL_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs come only from registered state, so nothing from the inputs reaches them combinationally.
  // Write enables are one-state pulses; gating with legal keeps them dead after an illegal decode.
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign ins       = ir_q;
  assign RegDst    = ctrl_q.reg_dst;
  assign ALUSrc    = ctrl_q.alu_src;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign Branch    = ctrl_q.branch;
  assign ALUOp     = ctrl_q.alu_op;
  assign MemWrite  = (state_q == S_MEM) && ctrl_q.is_sw && ctrl_q.legal;
  assign RegWrite  = (state_q == S_WB) && ctrl_q.legal;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed table, hand sequences, random instruction stream.
// Latency: n/a.
// Backpressure: the bench plays instruction memory and varies ack delay.
module tb_cpu_ctrl_fsm;

  logic        clk, rst, run, imem_req, imem_ack, zero;
  logic [31:0] imem_addr, imem_rdata, ins;
  logic        MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, halted, illegal;
  logic [3:0]  ALUOp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] word;
    logic        zero;
    int          delay;
    logic [7:0]  ctrl;   // {RegDst, ALUSrc, MemtoReg, Branch, ALUOp}
    logic [7:0]  mask;   // fields that are defined for this instruction
    int          k;      // cycles after the fetch
    int          rw;
    int          mw;
    int          delta;  // next PC minus instruction address
  } vec_t;

  vec_t tbl[10];

  cpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .zero(zero),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [44:0] all_outs();
    return {imem_req, ins, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUOp, halted, illegal};
  endfunction

  // Reference: expected behaviour of one instruction straight from the instruction table.
  function automatic vec_t ref_model(input logic [31:0] w, input logic z, input int d);
    vec_t v;
    v.word = w; v.zero = z; v.delay = d;
    v.ctrl = 8'h00; v.mask = 8'hFF; v.k = 0; v.rw = 0; v.mw = 0; v.delta = 4;
    case (w[31:26])
      6'h00: begin
        v.k = 3; v.rw = 1;
        case (w[5:0])
          6'h20: v.ctrl = 8'h02;
          6'h22: v.ctrl = 8'h06;
          6'h24: v.ctrl = 8'h00;
          6'h25: v.ctrl = 8'h01;
          6'h2A: v.ctrl = 8'h07;
          default: v.ctrl = 8'h00;
        endcase
      end
      6'h08: begin v.ctrl = 8'hC2; v.k = 3; v.rw = 1; end
      6'h23: begin v.ctrl = 8'hE2; v.k = 4; v.rw = 1; end
      6'h2B: begin v.ctrl = 8'h42; v.mask = 8'h5F; v.k = 3; v.mw = 1; end
      6'h04: begin
        v.ctrl = 8'h16; v.mask = 8'h5F; v.k = 2;
        if (z) v.delta = 4 + 4 * int'($signed(w[15:0]));
      end
      default: ;
    endcase
    return v;
  endfunction

  // Drive one instruction through fetch/execute and compare everything observable.
  task automatic run_instr(input vec_t v);
    int cyc, rw, mw, both, insbad, bad, guard;
    logic [31:0] ins0, addr0;
    logic [7:0]  ctl;
    cyc = 0; rw = 0; mw = 0; both = 0; insbad = 0; bad = 0; guard = 0; ctl = 8'h00;
    imem_ack = 1'b0;
    while (!imem_req && guard < 50) begin @(negedge clk); guard++; end
    check("fetch_start", imem_req, 1);
    check("fetch_addr", imem_addr, model_pc);
    zero = v.zero;
    ins0 = ins; addr0 = imem_addr;
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk); cyc++;
      if (!imem_req || imem_addr !== addr0 || ins !== ins0) bad++;
    end
    if (v.delay > 0) check("stall_hold", bad, 0);
    imem_ack = 1'b1; imem_rdata = v.word;
    @(negedge clk); cyc++;
    guard = 0;
    while (!imem_req && !halted && guard < 20) begin
      rw += int'(RegWrite); mw += int'(MemWrite);
      if (RegWrite && MemWrite) both++;
      if (ins !== v.word) insbad++;
      ctl = {RegDst, ALUSrc, MemtoReg, Branch, ALUOp};
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      @(negedge clk); cyc++; guard++;
    end
    imem_ack = 1'b0;
    check("cycles", cyc, v.delay + 1 + v.k);
    check("regwrite_pulses", rw, v.rw);
    check("memwrite_pulses", mw, v.mw);
    check("we_overlap", both, 0);
    check("ins_stable", insbad, 0);
    check("ctrl", ctl & v.mask, v.ctrl & v.mask);
    check("not_halted", halted, 0);
    model_pc = model_pc + v.delta;
  endtask

  // Illegal word: must halt with no writes and stay halted until reset.
  task automatic do_illegal(input logic [31:0] w);
    int guard, wr, bad;
    guard = 0; wr = 0; bad = 0;
    while (!imem_req && guard < 50) begin @(negedge clk); guard++; end
    check("ill_fetch_addr", imem_addr, model_pc);
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    guard = 0;
    while (!halted && guard < 5) begin
      wr += int'(RegWrite) + int'(MemWrite);
      @(negedge clk); guard++;
    end
    check("ill_halted", halted, 1);
    check("ill_flag", illegal, 1);
    for (int i = 0; i < 8; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      wr += int'(RegWrite) + int'(MemWrite);
      if (imem_req || !halted || !illegal) bad++;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    check("ill_no_writes", wr, 0);
    check("ill_absorbing", bad, 0);
    #1 rst = 1'b1;
    #1 check("ill_cleared_by_rst", {halted, illegal}, 2'b00);
    @(negedge clk) rst = 1'b0;
    model_pc = 32'h0;
  endtask

  initial begin
    int guard, bad;
    logic [31:0] w, rnd;
    logic [5:0]  fn;
    int kind;

    tbl[0] = '{32'h00221820, 1'b0, 0, 8'h02, 8'hFF, 3, 1, 0, 4};   // add   @0x00
    tbl[1] = '{32'h8C430004, 1'b0, 1, 8'hE2, 8'hFF, 4, 1, 0, 4};   // lw    @0x04
    tbl[2] = '{32'hAC430004, 1'b0, 0, 8'h42, 8'h5F, 3, 0, 1, 4};   // sw    @0x08
    tbl[3] = '{32'h20010005, 1'b0, 2, 8'hC2, 8'hFF, 3, 1, 0, 4};   // addi  @0x0C
    tbl[4] = '{32'h1022FFFE, 1'b1, 0, 8'h16, 8'h5F, 2, 0, 0, -4};  // beq taken @0x10 -> 0x0C
    tbl[5] = '{32'h00221824, 1'b0, 0, 8'h00, 8'hFF, 3, 1, 0, 4};   // and   @0x0C
    tbl[6] = '{32'h1022FFFE, 1'b0, 1, 8'h16, 8'h5F, 2, 0, 0, 4};   // beq not taken @0x10 -> 0x14
    tbl[7] = '{32'h00221825, 1'b1, 3, 8'h01, 8'hFF, 3, 1, 0, 4};   // or, 3-cycle ack stall
    tbl[8] = '{32'h00221822, 1'b1, 0, 8'h06, 8'hFF, 3, 1, 0, 4};   // sub
    tbl[9] = '{32'h0022182A, 1'b0, 0, 8'h07, 8'hFF, 3, 1, 0, 4};   // slt

    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; zero = 1'b0;
    model_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 45'h0);
    check("reset_pc", imem_addr, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_without_run", imem_req, 0);
    run = 1'b1;

    for (int i = 0; i < 10; i++) run_instr(tbl[i]);

    // run dropped during EXEC of an add: it finishes, then the sequencer parks.
    guard = 0;
    while (!imem_req && guard < 50) begin @(negedge clk); guard++; end
    check("drop_fetch_addr", imem_addr, model_pc);
    imem_ack = 1'b1; imem_rdata = 32'h00221820;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); run = 1'b0;
    @(negedge clk); check("drop_wb_completes", RegWrite, 1);
    @(negedge clk); @(negedge clk);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      bad += int'(imem_req) + int'(RegWrite) + int'(MemWrite);
      @(negedge clk);
    end
    check("drop_parked", bad, 0);
    model_pc = model_pc + 4;
    run = 1'b1;
    guard = 0;
    while (!imem_req && guard < 10) begin @(negedge clk); guard++; end
    check("resume_fetch_addr", imem_addr, model_pc);

    // Random legal instruction stream against the reference.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 8);
      rnd  = $urandom;
      case (kind)
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        default: fn = 6'h2A;
      endcase
      case (kind)
        5:       w = {6'h08, rnd[25:0]};
        6:       w = {6'h23, rnd[25:0]};
        7:       w = {6'h2B, rnd[25:0]};
        8:       w = {6'h04, rnd[25:0]};
        default: w = {6'h00, rnd[25:6], fn};
      endcase
      run_instr(ref_model(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3)));
    end

    do_illegal(32'hFC000000);
    do_illegal(32'h00221821);

    // Asynchronous reset landing mid-cycle while RegWrite is high.
    guard = 0;
    while (!imem_req && guard < 50) begin @(negedge clk); guard++; end
    check("pre_reset_fetch_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h00221820;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); check("pre_reset_wb", RegWrite, 1);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", all_outs(), 45'h0);
    check("async_reset_pc", imem_addr, 32'h0);
    @(negedge clk) rst = 1'b0;
    guard = 0;
    while (!imem_req && guard < 10) begin @(negedge clk); guard++; end
    check("post_reset_fetch", {imem_req, imem_addr}, {1'b1, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
